row_mac_engine: RTL and testbench

- Parametrised multi-row dot-product engine for the classifier's fully-connected layer.
- Streams packed pixel words and packed signed weight words from synchronous-read memories and accumulates LANES products per cycle.
- Processes a programmable run of consecutive weight rows per start and emits one result per row through a valid/ready output.
- Adds signed weights, selectable saturate/wrap, per-row overflow, multi-row batching and output backpressure.

---
 rtl/row_mac_pkg.sv | 23 ++
 rtl/mac_lane_array.sv | 50 +++++
 rtl/row_mac_engine.sv | 167 ++++++++++++++++
 tb/tb_row_mac_engine.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_mac_pkg.sv
// row_mac_engine shared types and width helpers.
// Row-by-row dot-product engine for the fully-connected layer.
package row_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUTPUT,
    DONE
  } state_t;

  // unsigned pixel times signed weight, as a signed product
  function automatic int prod_w(int pix_w, int wt_w);
    return pix_w + wt_w + 1;
  endfunction

  // accumulator wide enough that n products can never overflow
  function automatic int int_w(int pix_w, int wt_w, int n);
    return pix_w + wt_w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_lane_array.sv
// Registered per-lane multiply followed by a lane sum.
// Pixels are unsigned, weights signed two's complement.
module mac_lane_array
  import row_mac_pkg::*;
#(
  parameter int LANES = 2,
  parameter int PIX_W = 8,
  parameter int WT_W  = 16,
  localparam int PROD_W = prod_w(PIX_W, WT_W),
  localparam int SUM_W  = PROD_W + $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [LANES*PIX_W-1:0]   pix,
  input  logic [LANES*WT_W-1:0]    wt,
  output logic                     out_valid,
  output logic signed [SUM_W-1:0]  sum
);

  logic signed [PROD_W-1:0] op_a [LANES];
  logic signed [PROD_W-1:0] op_b [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];

  // widen each lane operand to the product width
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      op_a[i] = PROD_W'($signed({1'b0, pix[i*PIX_W +: PIX_W]}));
      op_b[i] = PROD_W'($signed(wt[i*WT_W +: WT_W]));
    end
  end

  // register the lane products and their valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      out_valid <= in_valid;
      for (int i = 0; i < LANES; i++) prod_q[i] <= op_a[i] * op_b[i];
    end
  end

  // sum the registered products, sign-extended
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(prod_q[i]);
  end

endmodule

// File: rtl/row_mac_engine.sv
// Multi-row dot-product engine: streams pixel and weight words,
// accumulates one row at a time and hands results out via valid/ready.
module row_mac_engine
  import row_mac_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int PIX_W     = 8,
  parameter int WT_W      = 16,
  parameter int VEC_WORDS = 392,
  parameter int NUM_ROWS  = 10,
  parameter int ACC_W     = 32,
  parameter int PIX_BASE  = 0,
  parameter int WT_BASE   = 0,
  localparam int ROW_W  = $clog2(NUM_ROWS),
  localparam int PIX_AW = 10,
  localparam int WT_AW  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ROW_W-1:0]       row_first,
  input  logic [ROW_W-1:0]       row_count,
  input  logic                   sat_en,
  output logic [PIX_AW-1:0]      pix_addr,
  input  logic [LANES*PIX_W-1:0] pix_data,
  output logic [WT_AW-1:0]       wt_addr,
  input  logic [LANES*WT_W-1:0]  wt_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ACC_W-1:0]       res_data,
  output logic [ROW_W-1:0]       res_row,
  output logic                   res_ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int INT_W  = int_w(PIX_W, WT_W, VEC_WORDS * LANES);
  localparam int PROD_W = prod_w(PIX_W, WT_W);
  localparam int SUM_W  = PROD_W + $clog2(LANES);
  localparam int K_W    = (VEC_WORDS > 1) ? $clog2(VEC_WORDS) : 1;
  localparam int EXT_W  = (INT_W > ACC_W) ? INT_W : ACC_W + 1;

  localparam logic [K_W-1:0]    K_LAST = K_W'(VEC_WORDS - 1);
  localparam logic [ROW_W:0]    NROWS  = (ROW_W + 1)'(NUM_ROWS);
  localparam logic [PIX_AW-1:0] PIX_B  = PIX_AW'(PIX_BASE);
  localparam logic [WT_AW-1:0]  WT_B   = WT_AW'(WT_BASE);
  localparam logic [WT_AW-1:0]  VW     = WT_AW'(VEC_WORDS);

  state_t state, state_n;

  logic [K_W-1:0]          k;
  logic                    drain_cnt;
  logic [ROW_W-1:0]        row;
  logic [ROW_W-1:0]        rows_left;
  logic                    sat_q;
  logic signed [INT_W-1:0] acc;
  logic                    fetch_d;
  logic                    prod_v;
  logic signed [SUM_W-1:0] lane_sum;
  logic                    start_ok;
  logic                    next_row;
  logic [ROW_W:0]          req_cnt;
  logic [ROW_W:0]          avail_cnt;
  logic [ROW_W:0]          eff_cnt;
  logic signed [EXT_W-1:0] acc_x;
  logic [EXT_W-ACC_W:0]    acc_hi;
  logic [ACC_W-1:0]        conv_data;
  logic                    conv_ovf;

  assign start_ok = start && ({1'b0, row_first} < NROWS);
  assign next_row = (state == OUTPUT) && res_ready && (rows_left != '0);

  // clamp the requested row count to at least one and to the rows left
  always_comb begin
    req_cnt   = (row_count == '0) ? (ROW_W + 1)'(1) : {1'b0, row_count};
    avail_cnt = NROWS - {1'b0, row_first};
    eff_cnt   = (req_cnt < avail_cnt) ? req_cnt : avail_cnt;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start_ok) state_n = FETCH;
      FETCH:  if (k == K_LAST) state_n = DRAIN;
      DRAIN:  if (drain_cnt) state_n = OUTPUT;
      OUTPUT: if (res_ready) state_n = (rows_left != '0) ? FETCH : DONE;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // counters, latched run settings and the row accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      drain_cnt <= 1'b0;
      row       <= '0;
      rows_left <= '0;
      sat_q     <= 1'b0;
      acc       <= '0;
      fetch_d   <= 1'b0;
    end else begin
      fetch_d   <= (state == FETCH);
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (state == FETCH) k <= (k == K_LAST) ? '0 : k + K_W'(1);
      if (state == IDLE && start_ok) begin
        row       <= row_first;
        rows_left <= ROW_W'(eff_cnt - (ROW_W + 1)'(1));
        sat_q     <= sat_en;
        acc       <= '0;
      end else if (next_row) begin
        row       <= row + ROW_W'(1);
        rows_left <= rows_left - ROW_W'(1);
        acc       <= '0;
      end else if (prod_v) begin
        acc <= acc + INT_W'(lane_sum);
      end
    end
  end

  mac_lane_array #(
    .LANES (LANES),
    .PIX_W (PIX_W),
    .WT_W  (WT_W)
  ) u_lanes (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fetch_d),
    .pix       (pix_data),
    .wt        (wt_data),
    .out_valid (prod_v),
    .sum       (lane_sum)
  );

  // clip or wrap the accumulator into the result width
  always_comb begin
    acc_x     = EXT_W'(acc);
    acc_hi    = acc_x[EXT_W-1:ACC_W-1];
    conv_data = acc_x[ACC_W-1:0];
    conv_ovf  = 1'b0;
    if (!((&acc_hi) || !(|acc_hi))) begin
      conv_ovf = 1'b1;
      if (sat_q) begin
        conv_data = acc_x[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

  assign pix_addr  = (state == FETCH) ? PIX_B + PIX_AW'(k) : PIX_B;
  assign wt_addr   = WT_B + WT_AW'(row) * VW
                   + ((state == FETCH) ? WT_AW'(k) : '0);
  assign res_valid = (state == OUTPUT);
  assign res_data  = res_valid ? conv_data : '0;
  assign res_ovf   = res_valid & conv_ovf;
  assign res_row   = res_valid ? row : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_row_mac_engine.sv
// Self-checking bench for row_mac_engine.
// Reference results come from a plain-arithmetic dot-product model.
module tb_row_mac_engine;

  localparam int LANES = 2;
  localparam int PIX_W = 8;
  localparam int WT_W  = 16;
  localparam int VW    = 392;
  localparam int NR    = 10;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start_s, sat_en, res_ready;
  logic [3:0]  row_first, row_count;

  logic [9:0]  pix_addr, pix_addr_s;
  logic [11:0] wt_addr, wt_addr_s;
  logic [15:0] pix_data, pix_data_s;
  logic [31:0] wt_data, wt_data_s;
  logic        res_valid, res_ovf, busy, done;
  logic        res_valid_s, res_ovf_s, busy_s, done_s;
  logic [31:0] res_data, res_data_s;
  logic [3:0]  res_row, res_row_s;

  logic [15:0] pix_mem [0:1023];
  logic [31:0] wt_mem  [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_data;
  logic        last_ovf;
  logic [3:0]  last_row;
  int          last_got;

  row_mac_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .row_first(row_first), .row_count(row_count), .sat_en(sat_en),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .wt_addr(wt_addr), .wt_data(wt_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_ovf(res_ovf), .busy(busy), .done(done)
  );

  row_mac_engine #(.VEC_WORDS(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s),
    .row_first(row_first), .row_count(row_count), .sat_en(sat_en),
    .pix_addr(pix_addr_s), .pix_data(pix_data_s),
    .wt_addr(wt_addr_s), .wt_data(wt_data_s),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s),
    .res_row(res_row_s), .res_ovf(res_ovf_s), .busy(busy_s), .done(done_s)
  );

  always @(posedge clk) begin
    pix_data   <= pix_mem[pix_addr];
    wt_data    <= wt_mem[wt_addr];
    pix_data_s <= pix_mem[pix_addr_s];
    wt_data_s  <= wt_mem[wt_addr_s];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void fill_const(logic [7:0] p, logic [15:0] w);
    for (int i = 0; i < 1024; i++) pix_mem[i] = {LANES{p}};
    for (int i = 0; i < 4096; i++) wt_mem[i] = {LANES{w}};
  endfunction

  function automatic void fill_rand(bit big);
    for (int i = 0; i < 1024; i++)
      pix_mem[i] = big ? {8'($urandom_range(200, 255)), 8'($urandom_range(200, 255))}
                       : 16'($urandom);
    for (int i = 0; i < 4096; i++)
      wt_mem[i] = big ? {16'($urandom_range(16'h6000, 16'h7FFF)),
                         16'($urandom_range(16'h6000, 16'h7FFF))}
                      : 32'($urandom);
  endfunction

  function automatic longint dot(int row, int vw);
    longint s = 0;
    logic [15:0] pw;
    logic [31:0] ww;
    for (int k = 0; k < vw; k++) begin
      pw = pix_mem[k];
      ww = wt_mem[row * vw + k];
      for (int l = 0; l < LANES; l++)
        s += longint'(pw[l*PIX_W +: PIX_W]) * longint'($signed(ww[l*WT_W +: WT_W]));
    end
    return s;
  endfunction

  function automatic logic [32:0] conv(longint v, bit sat);
    if (v > MAXV || v < MINV) begin
      if (sat) return {1'b1, (v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF};
      return {1'b1, v[31:0]};
    end
    return {1'b0, v[31:0]};
  endfunction

  task automatic run_job(input int rf, input int rc, input bit sat,
                         input bit rand_ready, input string tag);
    int eff, got, er;
    bit stall, done_seen, chk_addr;
    logic [31:0] pd;
    logic [3:0]  pr;
    logic [32:0] ex;
    eff = (rc == 0) ? 1 : rc;
    if (eff > NR - rf) eff = NR - rf;
    got = 0; stall = 0; done_seen = 0; chk_addr = 0; pd = '0; pr = '0;
    row_first = 4'(rf); row_count = 4'(rc); sat_en = sat;
    res_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    row_first = 4'($urandom); row_count = 4'($urandom); sat_en = ~sat;
    for (int b = 0; b < 30000 && !done_seen; b++) begin
      if (chk_addr) begin
        chk_addr = 0;
        n_checks++;
        if (wt_addr !== 12'((rf + got) * VW)) begin
          n_fail++;
          $display("FAIL %s row_addr: got %0d expected %0d", tag, wt_addr, (rf + got) * VW);
        end
      end
      if (stall) begin
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== pd || res_row !== pr) begin
          n_fail++;
          $display("FAIL %s hold: got v=%b d=%h r=%0d expected v=1 d=%h r=%0d",
                   tag, res_valid, res_data, res_row, pd, pr);
        end
      end
      if (done) begin
        done_seen = 1;
        n_checks++;
        if (got != eff) begin
          n_fail++;
          $display("FAIL %s result_count: got %0d expected %0d", tag, got, eff);
        end
      end else begin
        res_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        stall = 0;
        if (res_valid) begin
          if (res_ready) begin
            er = rf + got;
            ex = conv(dot(er, VW), sat);
            n_checks++;
            if (got >= eff || res_row !== 4'(er)) begin
              n_fail++;
              $display("FAIL %s res_row: got %0d expected %0d (result %0d of %0d)",
                       tag, res_row, er, got + 1, eff);
            end
            n_checks++;
            if ({res_ovf, res_data} !== ex) begin
              n_fail++;
              $display("FAIL %s res_data: got ovf=%b %h expected ovf=%b %h",
                       tag, res_ovf, res_data, ex[32], ex[31:0]);
            end
            last_data = res_data; last_ovf = res_ovf; last_row = res_row;
            got++;
            chk_addr = (got < eff);
          end else begin
            stall = 1; pd = res_data; pr = res_row;
          end
        end
        cyc();
      end
    end
    n_checks++;
    if (!done_seen) begin
      n_fail++;
      $display("FAIL %s timeout: got no done expected done", tag);
    end
    last_got = got;
    res_ready = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: got busy=%b done=%b expected 0 0", tag, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    n_checks++;
    if ({res_valid, res_ovf, busy, done, res_data, res_row, pix_addr, wt_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b o=%b b=%b d=%b %h r=%0d pa=%0d wa=%0d expected all 0",
               res_valid, res_ovf, busy, done, res_data, res_row, pix_addr, wt_addr);
    end
    n_checks++;
    if ({res_valid_s, busy_s, done_s, res_data_s} !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got v=%b b=%b d=%b %h expected all 0",
               res_valid_s, busy_s, done_s, res_data_s);
    end
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_latency();
    int m;
    fill_const(8'd1, 16'd1);
    row_first = 4'd5; row_count = 4'd1; sat_en = 1'b0; res_ready = 1'b1;
    start_s = 1'b1;
    cyc();
    start_s = 1'b0;
    m = 1;
    n_checks++;
    if (wt_addr_s !== 12'd20 || pix_addr_s !== 10'd0 || busy_s !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_first_addr: got wa=%0d pa=%0d b=%b expected 20 0 1",
               wt_addr_s, pix_addr_s, busy_s);
    end
    while (!res_valid_s && m < 40) begin
      cyc();
      m++;
    end
    n_checks++;
    if (m != 7) begin
      n_fail++;
      $display("FAIL lat_valid_cycle: got S+%0d expected S+7", m);
    end
    n_checks++;
    if (res_data_s !== 32'd8 || res_row_s !== 4'd5 || res_ovf_s !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_result: got %h r=%0d o=%b expected 8 r=5 o=0",
               res_data_s, res_row_s, res_ovf_s);
    end
    cyc();
    n_checks++;
    if (done_s !== 1'b1 || res_valid_s !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_done: got done=%b v=%b at S+8 expected 1 0", done_s, res_valid_s);
    end
    cyc();
    n_checks++;
    if (busy_s !== 1'b0 || done_s !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_idle: got busy=%b done=%b expected 0 0", busy_s, done_s);
    end
  endtask

  task automatic test_overflow();
    fill_const(8'hFF, 16'h8000);
    run_job(0, 1, 1'b1, 1'b0, "ovf_neg_sat");
    n_checks++;
    if (last_data !== 32'h8000_0000 || last_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg_sat: got %h o=%b expected 80000000 o=1", last_data, last_ovf);
    end
    run_job(0, 1, 1'b0, 1'b0, "ovf_neg_wrap");
    n_checks++;
    if (last_data !== 32'h7988_0000 || last_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_neg_wrap: got %h o=%b expected 79880000 o=1", last_data, last_ovf);
    end
    fill_const(8'hFF, 16'h7FFF);
    run_job(0, 1, 1'b1, 1'b0, "ovf_pos_sat");
    n_checks++;
    if (last_data !== 32'h7FFF_FFFF || last_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos_sat: got %h o=%b expected 7fffffff o=1", last_data, last_ovf);
    end
  endtask

  task automatic test_batch_clip();
    fill_rand(1'b0);
    run_job(8, 5, 1'b0, 1'b1, "batch_clip");
    n_checks++;
    if (last_got != 2 || last_row !== 4'd9) begin
      n_fail++;
      $display("FAIL batch_rows: got %0d rows last=%0d expected 2 rows last=9", last_got, last_row);
    end
  endtask

  task automatic test_bad_start();
    bit ok;
    ok = 1;
    row_first = 4'd10; row_count = 4'd1; start = 1'b1;
    cyc();
    row_first = 4'd15;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy || res_valid || done) ok = 0;
      cyc();
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bad_start: got busy activity expected none");
    end
  endtask

  task automatic test_backpressure();
    int b;
    logic [31:0] d0;
    logic [32:0] ex;
    fill_rand(1'b0);
    row_first = 4'd3; row_count = 4'd2; sat_en = 1'b0; res_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    b = 0;
    while (!res_valid && b < 2000) begin cyc(); b++; end
    d0 = res_data;
    ex = conv(dot(3, VW), 1'b0);
    n_checks++;
    if (res_valid !== 1'b1 || {res_ovf, res_data} !== ex || res_row !== 4'd3) begin
      n_fail++;
      $display("FAIL bp_first: got v=%b %h r=%0d expected v=1 %h r=3",
               res_valid, res_data, res_row, ex[31:0]);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== d0 || res_row !== 4'd3) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b %h r=%0d expected v=1 %h r=3",
                 res_valid, res_data, res_row, d0);
      end
    end
    res_ready = 1'b1;
    cyc();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1 || wt_addr !== 12'(4 * VW) || pix_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL bp_next0: got v=%b b=%b wa=%0d pa=%0d expected 0 1 %0d 0",
               res_valid, busy, wt_addr, pix_addr, 4 * VW);
    end
    cyc();
    n_checks++;
    if (wt_addr !== 12'(4 * VW + 1) || pix_addr !== 10'd1) begin
      n_fail++;
      $display("FAIL bp_next1: got wa=%0d pa=%0d expected %0d 1", wt_addr, pix_addr, 4 * VW + 1);
    end
    row_first = 4'd0; row_count = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++;
    if (wt_addr !== 12'(4 * VW + 2)) begin
      n_fail++;
      $display("FAIL start_in_fetch: got wa=%0d expected %0d", wt_addr, 4 * VW + 2);
    end
    b = 0;
    while (!res_valid && b < 2000) begin cyc(); b++; end
    ex = conv(dot(4, VW), 1'b0);
    n_checks++;
    if (res_valid !== 1'b1 || {res_ovf, res_data} !== ex || res_row !== 4'd4) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b %h r=%0d expected v=1 %h r=4",
               res_valid, res_data, res_row, ex[31:0]);
    end
    cyc();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: got %b expected 1", done);
    end
    cyc();
  endtask

  task automatic test_reset_midrun();
    bit ok;
    fill_rand(1'b0);
    row_first = 4'd1; row_count = 4'd3; sat_en = 1'b1; res_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100; i++) cyc();
    n_checks++;
    if (pix_addr !== 10'd100 || wt_addr !== 12'(VW + 100)) begin
      n_fail++;
      $display("FAIL mid_addr: got pa=%0d wa=%0d expected 100 %0d", pix_addr, wt_addr, VW + 100);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if ({res_valid, res_ovf, busy, done, res_data, res_row, pix_addr, wt_addr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b o=%b b=%b d=%b %h pa=%0d wa=%0d expected all 0",
               res_valid, res_ovf, busy, done, res_data, pix_addr, wt_addr);
    end
    ok = 1;
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (res_valid || done || busy) ok = 0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL mid_abort: got activity after reset expected none");
    end
    run_job(2, 2, 1'b1, 1'b1, "post_reset");
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      fill_rand(j[0]);
      run_job(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0; sat_en = 1'b0; res_ready = 1'b1;
    row_first = '0; row_count = '0;
    fill_const(8'd0, 16'd0);
    test_reset();
    test_latency();
    test_overflow();
    test_batch_clip();
    test_bad_start();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
